// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch unit.
// Holds the fetch state encoding, geometry constants and the lane offset helper.
package mips_fetch_pkg;

    localparam int unsigned BYTES_PER_INSTR = 4;
    localparam int unsigned PC_WIDTH        = 8;
    localparam int unsigned INSTR_WIDTH     = 8 * BYTES_PER_INSTR;

    localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = PC_WIDTH'(0);

    typedef enum logic [2:0] {
        F0   = 3'd0,
        F1   = 3'd1,
        F2   = 3'd2,
        F3   = 3'd3,
        HOLD = 3'd4
    } fetch_state_e;

    // Byte offset from pc that a fetch state reads.
    function automatic logic [PC_WIDTH-1:0] lane_offset(input fetch_state_e s);
        case (s)
            F1:      lane_offset = PC_WIDTH'(1);
            F2:      lane_offset = PC_WIDTH'(2);
            F3:      lane_offset = PC_WIDTH'(3);
            default: lane_offset = PC_WIDTH'(0);
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: reads four bytes little-endian from an 8-bit
// memory, presents the word to decode, and honours jump/branch redirects.
module instr_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    mem_addr,
    output logic                   mem_rd,
    input  logic [7:0]             mem_rdata,
    input  logic                   mem_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [PC_WIDTH-1:0]    pc_plus4,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_target
);

    fetch_state_e           state, state_next;
    logic [PC_WIDTH-1:0]    pc, pc_next;
    logic [INSTR_WIDTH-1:0] instr_next;
    logic [PC_WIDTH-1:0]    mem_addr_next;
    logic                   mem_rd_next;
    logic                   instr_valid_next;
    logic                   byte_done;

    // A byte is only taken while a read is actually being presented; this keeps
    // the first edge after reset from consuming data while mem_rd is still low.
    assign byte_done = mem_rd & mem_ready;

    assign pc_out   = pc;
    assign pc_plus4 = pc + PC_WIDTH'(BYTES_PER_INSTR);

    // State, pc, byte lanes and the registered memory/decode strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= F0;
            pc          <= RESET_PC;
            instr       <= '0;
            mem_addr    <= RESET_PC;
            mem_rd      <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            mem_addr    <= mem_addr_next;
            mem_rd      <= mem_rd_next;
            instr_valid <= instr_valid_next;
        end
    end

    // Next-state, pc and byte-lane update; redirect overrides everything.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr;

        if (redirect) begin
            state_next = F0;
            pc_next    = redirect_target & ~PC_WIDTH'(3);
        end else begin
            case (state)
                F0: if (byte_done) begin
                    instr_next[7:0]   = mem_rdata;
                    state_next        = F1;
                end
                F1: if (byte_done) begin
                    instr_next[15:8]  = mem_rdata;
                    state_next        = F2;
                end
                F2: if (byte_done) begin
                    instr_next[23:16] = mem_rdata;
                    state_next        = F3;
                end
                F3: if (byte_done) begin
                    instr_next[31:24] = mem_rdata;
                    state_next        = HOLD;
                end
                HOLD: if (instr_ready) begin
                    pc_next    = pc + PC_WIDTH'(BYTES_PER_INSTR);
                    state_next = F0;
                end
                default: state_next = F0;
            endcase
        end

        mem_rd_next      = (state_next != HOLD);
        instr_valid_next = (state_next == HOLD);
        mem_addr_next    = pc_next + lane_offset(state_next);
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00: byte address of the first fetch after reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mem_addr  output  8  byte address presented to the instruction memory.
REQ-005 mem_rd  output  1  read request; mem_addr is valid while high.
REQ-006 mem_rdata  input  8  read data; valid in any cycle where mem_rd and mem_ready are both 1.
REQ-007 mem_ready  input  1  memory completes the current byte read this cycle.
REQ-008 instr  output  32  assembled instruction word.
REQ-009 instr_valid  output  1  instr and pc_out are valid.
REQ-010 instr_ready  input  1  decode stage accepts instr this cycle.
REQ-011 pc_out  output  8  address of the byte in instr[7:0].
REQ-012 pc_plus4  output  8  pc_out + 4, mod 256; feeds the branch/jump target adders.
REQ-013 redirect  input  1  jump or taken branch; discard the in-flight fetch.
REQ-014 redirect_target  input  8  new byte address from the jump/branch path; bits [1:0] ignored.

Function
REQ-015 The state machine SHALL have five states: F0, F1, F2, F3 (fetch byte k) and HOLD (word complete).
REQ-016 In state Fk: mem_rd=1, mem_addr=pc+k mod 256, instr_valid=0.
REQ-017 In Fk with mem_ready=1: mem_rdata latched into instr[8k+7:8k] (little-endian); next state F(k+1), or HOLD from F3.
REQ-018 In Fk with mem_ready=0: no state change, byte not latched, mem_addr held.
REQ-019 In HOLD: mem_rd=0, instr_valid=1, instr and pc_out stable.
REQ-020 HOLD with instr_ready=1: pc <= pc+4 mod 256 (8'hFC wraps to 8'h00); next state F0.
REQ-021 HOLD with instr_ready=0: remain in HOLD.
REQ-022 Minimum latency: 4 cycles from F0 entry to instr_valid=1 with mem_ready held high; throughput is one word per 5 cycles.
REQ-023 Redirect has priority over every other event in every state.
  - Effect: pc <= {redirect_target[7:2],2'b00}; next state F0.
  - Partial bytes are discarded.
  - A byte arriving in the redirect cycle is not latched.
REQ-024 Redirect with instr_ready=1 in HOLD: the word counts as consumed; pc SHALL take the redirect target, not pc+4.
REQ-025 Redirect in F0 while already at the target address SHALL restart the F0 read; no error.
REQ-026 pc_out SHALL equal the internal pc register; pc_plus4 SHALL equal pc+4 mod 256 combinationally.
REQ-027 instr bytes not yet fetched for the current word hold stale values; consumers SHALL qualify instr with instr_valid.

Reset
REQ-028 While reset=0, asynchronously:
  - state=F0, pc=RESET_PC, instr=32'h0, instr_valid=0.
  - mem_rd=0 (forced low during reset), mem_addr=RESET_PC.
REQ-029 On the first clk edge after reset rises: mem_rd=1 with mem_addr=RESET_PC.
REQ-030 Reset asserted mid-fetch or in HOLD SHALL abandon the word; no partial-state retention.

Structure
REQ-031 Shared package mips_fetch_pkg SHALL hold:
  - the fetch state enumeration (F0..F3, HOLD);
  - BYTES_PER_INSTR=4;
  - PC_WIDTH=8;
  - the default RESET_PC.
REQ-032 Single module, no sub-module: the FSM, pc register and byte-lane register live in instr_fetch.

Verification
REQ-033 Reset release, mem_ready=1, bytes 8'h20,8'h08,8'h00,8'h05 -> mem_addr 00,01,02,03; instr_valid after 4 cycles; instr=32'h05000820; pc_out=00; pc_plus4=04.
REQ-034 mem_ready low for 3 cycles in F2 -> mem_addr held at pc+2; bytes F0/F1 unchanged; completion delayed by exactly 3 cycles.
REQ-035 HOLD with instr_ready=0 for 5 cycles -> instr_valid=1, instr stable, mem_rd=0; then instr_ready=1 -> next mem_addr=04.
REQ-036 redirect=1, redirect_target=8'h17, during F2 -> next cycle F0 with mem_addr=8'h14; old partial bytes never surface.
REQ-037 pc=8'hFC word consumed -> next mem_addr=8'h00; redirect together with instr_ready in HOLD -> fetch resumes at the target, not pc+4.
REQ-038 reset=0 asserted asynchronously mid-F3 -> instr_valid=0 and mem_rd=0 immediately; refetch from RESET_PC after release.
